// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
// Single-clock FIFO between the sample formatter and the frame/DDR writer.
// Storage is a simple-dual-port RAM addressed by wrap-bit pointers. The
// read side is either the RAM read register (standard mode, one cycle after
// rd_en) or, with c_FWFT = 1, a prefetch stage that presents the head word on
// rd_data while rd_empty is low.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           asynchronous, active-high reset; discards all contents
//   wr_data       write data
//   wr_en         write request; dropped while wr_full (sets overflow)
//   wr_full       level == 2**c_DEPTH_WIDTH
//   almost_full   level >= c_ALMOST_FULL_NUM
//   rd_en         read request / pop
//   rd_data       read data
//   rd_empty      no word readable
//   almost_empty  level <= c_ALMOST_EMPTY_NUM
//   water_level   words held (FWFT: includes the word on rd_data)
//   overflow      sticky, write attempted while full
//   underflow     sticky, read attempted while empty
//   clr_err       synchronous clear of overflow/underflow; a new error wins
module sync_fifo_fwft #(
   parameter int c_DATA_WIDTH       = 16,
   parameter int c_DEPTH_WIDTH      = 4,
   parameter int c_FWFT             = 0,
   parameter int c_ALMOST_FULL_NUM  = 14,
   parameter int c_ALMOST_EMPTY_NUM = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [c_DATA_WIDTH-1:0]  wr_data,
   input  logic                     wr_en,
   output logic                     wr_full,
   output logic                     almost_full,
   input  logic                     rd_en,
   output logic [c_DATA_WIDTH-1:0]  rd_data,
   output logic                     rd_empty,
   output logic                     almost_empty,
   output logic [c_DEPTH_WIDTH:0]   water_level,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     clr_err
);

   localparam int N = 2 ** c_DEPTH_WIDTH;
   localparam logic [c_DEPTH_WIDTH:0] PTR_ONE  = (c_DEPTH_WIDTH+1)'(1);
   localparam logic [c_DEPTH_WIDTH:0] LVL_FULL = (c_DEPTH_WIDTH+1)'(N);
   localparam logic [c_DEPTH_WIDTH:0] LVL_AF   = (c_DEPTH_WIDTH+1)'(c_ALMOST_FULL_NUM);
   localparam logic [c_DEPTH_WIDTH:0] LVL_AE   = (c_DEPTH_WIDTH+1)'(c_ALMOST_EMPTY_NUM);

   logic [c_DATA_WIDTH-1:0]  mem [N];
   logic [c_DEPTH_WIDTH:0]   wr_ptr;
   logic [c_DEPTH_WIDTH:0]   rd_ptr;
   logic [c_DEPTH_WIDTH:0]   level;
   logic [c_DEPTH_WIDTH:0]   level_nxt;
   logic [c_DATA_WIDTH-1:0]  ram_q;
   logic                     wr_acc;
   logic                     ram_rd;
   logic                     ram_empty;
   logic                     rd_acc;

   // RAM-side emptiness: pointers equal including the wrap bit.
   assign ram_empty = (wr_ptr == rd_ptr);
   assign wr_acc    = wr_en & ~wr_full;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[c_DEPTH_WIDTH-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ram_q  <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (ram_rd) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            ram_q  <= mem[rd_ptr[c_DEPTH_WIDTH-1:0]];
         end
      end
   end

   generate
      if (c_FWFT == 0) begin : g_std
         assign ram_rd   = rd_en & ~ram_empty;
         assign rd_acc   = ram_rd;
         assign rd_data  = ram_q;
         assign rd_empty = ram_empty;
      end else begin : g_fwft
         // Two-deep read pipeline: ram_q (q_valid) feeds the output stage
         // (out_valid). The RAM is read whenever ram_q is free or is being
         // moved forward this cycle, so a continuous pop drains one word per
         // cycle once both stages are primed.
         logic                    q_valid;
         logic                    out_valid;
         logic                    load;
         logic                    pop;
         logic [c_DATA_WIDTH-1:0] out_data;

         assign pop    = rd_en & out_valid;
         assign load   = q_valid & (~out_valid | pop);
         assign ram_rd = ~ram_empty & (~q_valid | load);
         assign rd_acc = pop;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               q_valid   <= 1'b0;
               out_valid <= 1'b0;
               out_data  <= '0;
            end else begin
               if (ram_rd) begin
                  q_valid <= 1'b1;
               end else if (load) begin
                  q_valid <= 1'b0;
               end
               if (load) begin
                  out_valid <= 1'b1;
                  out_data  <= ram_q;
               end else if (pop) begin
                  out_valid <= 1'b0;
               end
            end
         end

         assign rd_data  = out_data;
         assign rd_empty = ~out_valid;
      end
   endgenerate

   always_comb begin
      level_nxt = level;
      case ({wr_acc, rd_acc})
         2'b10:   level_nxt = level + PTR_ONE;
         2'b01:   level_nxt = level - PTR_ONE;
         default: level_nxt = level;
      endcase
   end

   // Flags are registered from the next level so they always agree with
   // water_level in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level        <= '0;
         wr_full      <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         level        <= level_nxt;
         wr_full      <= (level_nxt == LVL_FULL);
         almost_full  <= (level_nxt >= LVL_AF);
         almost_empty <= (level_nxt <= LVL_AE);
         overflow     <= (wr_en & wr_full)  | (overflow  & ~clr_err);
         underflow    <= (rd_en & rd_empty) | (underflow & ~clr_err);
      end
   end

   assign water_level = level;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: one standard-mode and one FWFT instance, each
// checked every cycle against a queue model, plus literal spot checks.
module tb_sync_fifo_fwft;

   localparam int DW = 16;
   localparam int AW = 4;
   localparam int N  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // standard-mode instance
   logic [DW-1:0] s_wdata = '0;
   logic          s_wen = 1'b0, s_ren = 1'b0, s_clr = 1'b0;
   logic [DW-1:0] s_rdata;
   logic          s_full, s_af, s_empty, s_ae, s_ovf, s_unf;
   logic [AW:0]   s_lvl;

   // FWFT instance
   logic [DW-1:0] f_wdata = '0;
   logic          f_wen = 1'b0, f_ren = 1'b0, f_clr = 1'b0;
   logic [DW-1:0] f_rdata;
   logic          f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
   logic [AW:0]   f_lvl;

   sync_fifo_fwft #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(0),
                    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) dut_std (
      .clk(clk), .rst(rst), .wr_data(s_wdata), .wr_en(s_wen), .wr_full(s_full),
      .almost_full(s_af), .rd_en(s_ren), .rd_data(s_rdata), .rd_empty(s_empty),
      .almost_empty(s_ae), .water_level(s_lvl), .overflow(s_ovf),
      .underflow(s_unf), .clr_err(s_clr));

   sync_fifo_fwft #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_FWFT(1),
                    .c_ALMOST_FULL_NUM(14), .c_ALMOST_EMPTY_NUM(2)) dut_fwft (
      .clk(clk), .rst(rst), .wr_data(f_wdata), .wr_en(f_wen), .wr_full(f_full),
      .almost_full(f_af), .rd_en(f_ren), .rd_data(f_rdata), .rd_empty(f_empty),
      .almost_empty(f_ae), .water_level(f_lvl), .overflow(f_ovf),
      .underflow(f_unf), .clr_err(f_clr));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- standard-mode model ----------------
   logic [DW-1:0] sq[$];
   logic [DW-1:0] s_exp_rd  = '0;
   bit            s_exp_ovf = 1'b0;
   bit            s_exp_unf = 1'b0;
   bit            s_was_empty, s_was_full;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sq.delete();
         s_exp_rd  = '0;
         s_exp_ovf = 1'b0;
         s_exp_unf = 1'b0;
      end else begin
         s_was_empty = (sq.size() == 0);
         s_was_full  = (sq.size() == N);
         if (s_ren && !s_was_empty) s_exp_rd = sq.pop_front();
         if (s_wen && !s_was_full)  sq.push_back(s_wdata);
         s_exp_ovf = (s_wen && s_was_full)  || (s_exp_ovf && !s_clr);
         s_exp_unf = (s_ren && s_was_empty) || (s_exp_unf && !s_clr);
      end
   end

   // ---------------- FWFT model ----------------
   // A word becomes readable two edges after the edge that wrote it
   // (RAM read latency plus output stage); only the head word is shown.
   logic [DW-1:0] fq[$];
   int            ft[$];
   int            cyc = 0;
   bit            f_exp_ovf = 1'b0;
   bit            f_exp_unf = 1'b0;
   bit            f_pre_empty, f_was_full;

   function automatic bit f_exp_empty();
      if (fq.size() == 0) return 1'b1;
      return (ft[0] + 2) > cyc;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         ft.delete();
         f_exp_ovf = 1'b0;
         f_exp_unf = 1'b0;
      end else begin
         f_pre_empty = f_exp_empty();
         f_was_full  = (fq.size() == N);
         cyc = cyc + 1;
         if (f_ren && !f_pre_empty) begin
            void'(fq.pop_front());
            void'(ft.pop_front());
         end
         if (f_wen && !f_was_full) begin
            fq.push_back(f_wdata);
            ft.push_back(cyc);
         end
         f_exp_ovf = (f_wen && f_was_full)  || (f_exp_ovf && !f_clr);
         f_exp_unf = (f_ren && f_pre_empty) || (f_exp_unf && !f_clr);
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!rst) begin
         check("std_level",     32'(s_lvl),   sq.size());
         check("std_full",      32'(s_full),  32'(sq.size() == N));
         check("std_afull",     32'(s_af),    32'(sq.size() >= 14));
         check("std_aempty",    32'(s_ae),    32'(sq.size() <= 2));
         check("std_empty",     32'(s_empty), 32'(sq.size() == 0));
         check("std_rd_data",   32'(s_rdata), 32'(s_exp_rd));
         check("std_overflow",  32'(s_ovf),   32'(s_exp_ovf));
         check("std_underflow", 32'(s_unf),   32'(s_exp_unf));
         check("fw_level",      32'(f_lvl),   fq.size());
         check("fw_full",       32'(f_full),  32'(fq.size() == N));
         check("fw_afull",      32'(f_af),    32'(fq.size() >= 14));
         check("fw_aempty",     32'(f_ae),    32'(fq.size() <= 2));
         check("fw_empty",      32'(f_empty), 32'(f_exp_empty()));
         if (!f_exp_empty()) check("fw_rd_data", 32'(f_rdata), 32'(fq[0]));
         check("fw_overflow",   32'(f_ovf),   32'(f_exp_ovf));
         check("fw_underflow",  32'(f_unf),   32'(f_exp_unf));
      end
   end

   task automatic s_step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr);
      s_wen = we; s_wdata = wd; s_ren = re; s_clr = clr;
      @(negedge clk);
      s_wen = 1'b0; s_ren = 1'b0; s_clr = 1'b0;
   endtask

   task automatic f_step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr);
      f_wen = we; f_wdata = wd; f_ren = re; f_clr = clr;
      @(negedge clk);
      f_wen = 1'b0; f_ren = 1'b0; f_clr = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int npop, bubbles;
   bit rw, rr;

   initial begin
      repeat (2) @(negedge clk);
      check("reset_level", 32'(s_lvl), 0);
      check("reset_empty", 32'(s_empty), 1);
      check("reset_aempty", 32'(s_ae), 1);
      rst = 1'b0;

      // 1. fill
      for (int i = 0; i < 16; i++) begin
         s_step(1'b1, 16'(i), 1'b0, 1'b0);
         if (i == 12) check("t1_afull_at13", 32'(s_af), 0);
         if (i == 13) check("t1_afull_at14", 32'(s_af), 1);
      end
      check("t1_full", 32'(s_full), 1);
      check("t1_level16", 32'(s_lvl), 16);

      // 2. overflow at full
      s_step(1'b1, 16'hBEEF, 1'b0, 1'b0);
      check("t2_overflow", 32'(s_ovf), 1);
      check("t2_level_after_drop", 32'(s_lvl), 16);

      // 1. drain
      for (int i = 0; i < 16; i++) begin
         s_step(1'b0, '0, 1'b1, 1'b0);
         check("t1_rd_data", 32'(s_rdata), i);
         if (i == 12) check("t1_aempty_at3", 32'(s_ae), 0);
         if (i == 13) check("t1_aempty_at2", 32'(s_ae), 1);
      end
      check("t1_empty", 32'(s_empty), 1);

      // 2. underflow and clear
      s_step(1'b0, '0, 1'b1, 1'b0);
      check("t2_underflow", 32'(s_unf), 1);
      check("t2_rd_data_held", 32'(s_rdata), 32'h000F);
      s_step(1'b0, '0, 1'b1, 1'b1);
      check("t2_clr_set_wins", 32'(s_unf), 1);
      check("t2_ovf_cleared", 32'(s_ovf), 0);
      s_step(1'b0, '0, 1'b0, 1'b1);
      check("t2_unf_cleared", 32'(s_unf), 0);

      // 3. simultaneous read/write
      for (int i = 0; i < 8; i++) s_step(1'b1, 16'(16'h0200 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) s_step(1'b1, 16'(16'h0300 + i), 1'b1, 1'b0);
      check("t3_level8", 32'(s_lvl), 8);
      check("t3_rd_data_order", 32'(s_rdata), 32'h030B);
      for (int i = 0; i < 8; i++) s_step(1'b1, 16'(16'h0400 + i), 1'b0, 1'b0);
      s_step(1'b1, 16'hDEAD, 1'b1, 1'b0);
      check("t3_full_rw_level", 32'(s_lvl), 15);
      check("t3_full_rw_data", 32'(s_rdata), 32'h030C);
      s_step(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) s_step(1'b0, '0, 1'b1, 1'b0);
      s_step(1'b1, 16'h7777, 1'b1, 1'b0);
      check("t3_empty_rw_level", 32'(s_lvl), 1);
      check("t3_empty_rw_unf", 32'(s_unf), 1);
      s_step(1'b0, '0, 1'b0, 1'b1);

      // 4. random push/pop holding level 3..12
      for (int i = 0; i < 5; i++) s_step(1'b1, 16'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         rw = (sq.size() < 12) && ($urandom_range(0, 1) == 1);
         rr = (sq.size() > 3)  && ($urandom_range(0, 1) == 1);
         s_step(rw, 16'($urandom), rr, 1'b0);
      end

      // 5. FWFT single word latency
      f_step(1'b1, 16'h00A5, 1'b0, 1'b0);
      check("t5_empty_edge0", 32'(f_empty), 1);
      f_step(1'b0, '0, 1'b0, 1'b0);
      check("t5_empty_edge1", 32'(f_empty), 1);
      f_step(1'b0, '0, 1'b0, 1'b0);
      check("t5_empty_edge2", 32'(f_empty), 0);
      check("t5_data_a5", 32'(f_rdata), 32'h00A5);
      f_step(1'b0, '0, 1'b1, 1'b0);
      check("t5_level_after_pop", 32'(f_lvl), 0);

      // 5. FWFT streaming
      npop = 0; bubbles = 0;
      for (int i = 0; i < 22; i++) begin
         if (!f_empty) begin
            check("t5_stream_data", 32'(f_rdata), 32'h0100 + npop);
            npop++;
         end else if (npop > 0 && npop < 16) begin
            bubbles++;
         end
         f_step(i < 16, 16'(16'h0100 + i), 1'b1, 1'b0);
      end
      check("t5_stream_count", npop, 16);
      check("t5_bubbles", bubbles, 0);

      // 6. reset mid-operation at level 9
      for (int i = 0; i < N + 2; i++) begin
         if (sq.size() > 0) s_step(1'b0, '0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 9; i++) s_step(1'b1, 16'(16'h0900 + i), 1'b0, 1'b0);
      s_step(1'b0, '0, 1'b1, 1'b0);
      s_step(1'b1, 16'h0909, 1'b0, 1'b0);
      check("t6_level9", 32'(s_lvl), 9);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_level",  32'(s_lvl), 0);
      check("t6_rst_empty",  32'(s_empty), 1);
      check("t6_rst_rdata",  32'(s_rdata), 0);
      check("t6_rst_full",   32'(s_full), 0);
      check("t6_rst_aempty", 32'(s_ae), 1);
      check("t6_rst_afull",  32'(s_af), 0);
      check("t6_rst_ovf",    32'(s_ovf), 0);
      check("t6_rst_unf",    32'(s_unf), 0);
      check("t6_rst_fw_empty", 32'(f_empty), 1);
      check("t6_rst_fw_rdata", 32'(f_rdata), 0);
      @(negedge clk);
      rst = 1'b0;
      s_step(1'b1, 16'h1234, 1'b0, 1'b0);
      s_step(1'b1, 16'h5678, 1'b0, 1'b0);
      s_step(1'b0, '0, 1'b1, 1'b0);
      check("t6_first_after_reset", 32'(s_rdata), 32'h1234);
      check("t6_level_after_reset", 32'(s_lvl), 1);
      s_step(1'b0, '0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
- Single-clock parametrised FIFO; successor to the dual-clock sdpram-plus-controller FIFO wrapper.
- Adds the following, selectable at elaboration:
  - first-word-fall-through (FWFT) or standard read mode;
  - programmable almost thresholds;
  - sticky overflow/underflow error flags;
  - exact occupancy count.
- Used in the oscilloscope capture path between the sample formatter and the frame/DDR writer, where both sides share one clock.

Parameters:
- c_DATA_WIDTH, 16: data width in bits, legal 1–256.
- c_DEPTH_WIDTH, 4: log2 of capacity, legal 2–12; capacity N = 2^c_DEPTH_WIDTH words.
- c_FWFT, 0: 0 = standard mode (data one cycle after rd_en); 1 = first-word-fall-through.
- c_ALMOST_FULL_NUM, 14: almost_full asserts when level >= this; legal 1..N.
- c_ALMOST_EMPTY_NUM, 2: almost_empty asserts when level <= this; legal 0..N-1.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_data  in  c_DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_full  out  1  level == N.
- almost_full  out  1  level >= c_ALMOST_FULL_NUM.
- rd_en  in  1  read request (pop).
- rd_data  out  c_DATA_WIDTH  read data.
- rd_empty  out  1  no word readable.
- almost_empty  out  1  level <= c_ALMOST_EMPTY_NUM.
- water_level  out  c_DEPTH_WIDTH+1  words held. In FWFT mode this includes the word presented on rd_data.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (async assert; release takes effect on the first clk edge after rst falls):
  - pointers and level = 0;
  - rd_data = 0, rd_empty = 1, wr_full = 0;
  - almost_empty = 1, almost_full = 0;
  - overflow = 0, underflow = 0.
  - A reset mid-operation discards all contents.
- Pointers:
  - wr_ptr and rd_ptr are c_DEPTH_WIDTH+1 bits with wrap bit.
  - Full when addresses are equal and wrap bits differ; empty when fully equal.
  - Wrap from N-1 to 0 is seamless.
- Write accepted = wr_en & !wr_full.
  - Data is stored at wr_ptr; wr_ptr increments.
  - A write while full is dropped: contents and pointers unchanged, overflow set.
  - wr_full uses the pre-edge state: a write in the same cycle as a read at full is still rejected.
- Standard mode (c_FWFT=0):
  - Read accepted = rd_en & !rd_empty.
  - rd_data updates on the next edge with the addressed word (1-cycle latency) and holds until the next accepted read.
  - A read while empty leaves rd_data unchanged and sets underflow.
  - rd_empty is pre-edge state, so a simultaneous write to an empty FIFO is accepted and the read is rejected.
- FWFT mode (c_FWFT=1):
  - Internal prefetch output stage.
  - rd_data is valid whenever rd_empty = 0; rd_en pops it.
  - After a write into an empty FIFO, rd_empty deasserts 2 cycles after the write edge. The memory has 1-cycle read latency plus the stage load.
  - Back-to-back rd_en sustains one word/cycle while level >= 2.
  - rd_en while rd_empty sets underflow and has no other effect.
- Level and flags:
  - water_level: +1 on accepted write, -1 on accepted read, unchanged on simultaneous accept of both.
  - Range 0..N; it never exceeds N.
  - wr_full, almost_full and almost_empty are registered and consistent with water_level in the same cycle.
  - In FWFT mode, rd_empty may lag water_level by the prefetch latency (level 1 with rd_empty 1 for one cycle is legal).
- Error flags:
  - clr_err clears both flags.
  - If a new error occurs in the same cycle as clr_err, the flag is set; set wins.
- Storage: inferred simple-dual-port RAM (write port, read port), no output register beyond the FWFT stage. Target 120–400 lines.

Test Plan:
1. Fill/drain, defaults (N=16, standard): write 0x0000..0x000F over 16 cycles.
   - wr_full = 1 and water_level = 16 after the 16th edge; almost_full from level 14.
   - Read 16: rd_data 0x0000..0x000F, each one cycle after rd_en; rd_empty = 1 and almost_empty asserted at level 2.
2. Overflow/underflow: at full, write 0xBEEF.
   - Dropped; overflow = 1; later reads never return 0xBEEF.
   - rd_en on empty sets underflow = 1.
   - clr_err with a simultaneous bad read leaves underflow = 1; clr_err alone clears it.
3. Simultaneous read/write:
   - At level 8: level stays 8 over 20 cycles, data order preserved.
   - At full: write rejected, read accepted, level 15.
   - At empty: read rejected, write accepted, level 1.
4. Wrap-around: 40 cycles of random push/pop holding level 3–12.
   - Output sequence equals the scoreboard; pointers wrap at least twice with no data error.
5. FWFT (c_FWFT=1): single write of 0x00A5 into empty.
   - rd_empty falls 2 cycles later with rd_data = 0x00A5 before any rd_en.
   - Then 16 writes plus continuous rd_en yield one word/cycle and no bubbles once primed.
6. Reset mid-operation: assert rst asynchronously at level 9 between edges.
   - All outputs reach reset values immediately: water_level 0, rd_empty 1, rd_data 0, flags 0.
   - After release, the first written word is the first read.
